ex_operand_stage: RTL
=====================

Name: ex_operand_stage

Overview:
- Registered EX-stage operand selection unit for the MIPS pipeline. It supersedes the single 2:1 ALU-source select.
- It resolves forwarding for both ALU operands and extends the immediate in one of three modes (sign, zero, upper).
- It selects operand B and registers op_a, op_b and store_data into the EX/MEM boundary.
- It supports stall (hold) and flush (bubble) so the hazard unit can control it directly.

Parameters:
- DATA_W, 32, datapath width in bits.
- IMM_W, 16, immediate field width; legal range is 1 to DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  the ID/EX instruction in this cycle is real (not a bubble).
- stall  input  1  hold all output registers.
- flush  input  1  replace the next output with a bubble.
- alu_src  input  2  operand B select: 0 = rt, 1 = sign-extended imm, 2 = zero-extended imm, 3 = upper imm.
- fwd_a  input  2  operand A source: 0 = data_rs, 1 = fwd_mem, 2 = fwd_wb, 3 = reserved (treated as 0).
- fwd_b  input  2  rt source, same encoding as fwd_a.
- data_rs  input  DATA_W  register-file rs value.
- data_rt  input  DATA_W  register-file rt value.
- imm  input  IMM_W  raw immediate field.
- fwd_mem  input  DATA_W  EX/MEM ALU result for forwarding.
- fwd_wb  input  DATA_W  MEM/WB writeback value for forwarding.
- out_valid  output  1  registered valid.
- op_a  output  DATA_W  registered ALU operand A.
- op_b  output  DATA_W  registered ALU operand B.
- store_data  output  DATA_W  registered forwarded rt, used for stores whatever alu_src is.

Behaviour:
- Reset: on a clk edge with reset=1, out_valid, op_a, op_b and store_data all become 0. Reset overrides stall and flush and takes effect in any state.
- Combinational front end:
  - a_next = forwarding mux on fwd_a.
  - rt_fwd = forwarding mux on fwd_b.
  - b_next = rt_fwd when alu_src=0; otherwise the extended immediate.
- Immediate extension:
  - Sign mode: imm[IMM_W-1] is replicated into bits DATA_W-1:IMM_W.
  - Zero mode: bits DATA_W-1:IMM_W are 0.
  - Upper mode: imm occupies bits DATA_W-1:DATA_W-IMM_W and the low bits are 0.
  - When IMM_W = DATA_W, all three modes yield imm unchanged.
- Latency: exactly 1 cycle from inputs to registered outputs; there is no combinational path from input to output.
- Update priority per clk edge: reset, then flush, then stall, then normal load.
  - flush=1: out_valid becomes 0 and op_a, op_b, store_data become 0. Flush wins over a simultaneous stall.
  - stall=1 (with flush=0): every output register keeps its value, and the inputs of that cycle are discarded.
  - Normal load: out_valid <= in_valid; op_a <= a_next; op_b <= b_next; store_data <= rt_fwd.
- Bubbles: when in_valid=0 the data registers still load the computed values; only out_valid marks the entry invalid. Downstream must qualify on out_valid.
- Reserved forwarding code 3 selects the register-file value. It is never X and never any other source.
- A stall that spans many cycles holds the outputs indefinitely. The first non-stall edge loads the inputs present on that cycle.

Decomposition:
- Shared package ex_pkg holds:
  - ALU_SRC_RT=0, ALU_SRC_SEXT=1, ALU_SRC_ZEXT=2, ALU_SRC_UPPER=3.
  - FWD_REG=0, FWD_MEM=1, FWD_WB=2.
- One sub-module, imm_extend (parameters DATA_W and IMM_W, purely combinational), takes imm and the 2-bit mode and produces the extended value.
- The forwarding muxes and the output register stay inline in ex_operand_stage.

Test Plan:
- Reset: reset=1 for 2 cycles with all inputs nonzero → every output is 0. Release reset with in_valid=1, data_rs=5, data_rt=7, alu_src=0, fwd=0 → one cycle later out_valid=1, op_a=5, op_b=7, store_data=7.
- Extension modes: imm=16'h8001 with alu_src=1,2,3 on successive cycles → op_b = FFFF8001, then 00008001, then 80010000, in order with 1-cycle latency. Store_data tracks data_rt in every case.
- Forwarding: fwd_a=1, fwd_b=2, fwd_mem=AAAA0000, fwd_wb=0000BBBB, alu_src=1, imm=0004 → op_a=AAAA0000, op_b=00000004, store_data=0000BBBB. Repeat with fwd_a=3 and data_rs=11 → op_a=11.
- Stall hold: load op_a=1, then assert stall for 3 cycles while data_rs=2,3,4, then deassert with data_rs=9 → op_a stays 1 for 3 cycles, then becomes 9.
- Flush priority: stall=1 and flush=1 together while out_valid=1 → next cycle out_valid=0 and all data outputs are 0. Flush alone with in_valid=1 gives the same result.
- Bubble and parameters: in_valid=0, data_rs=3 → out_valid=0 and op_a=3. Re-run the extension-mode test with DATA_W=16, IMM_W=16 → op_b=8001 in all three modes.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings for the EX-stage operand path: operand-B source and forwarding source codes.
package ex_pkg;

    localparam logic [1:0] ALU_SRC_RT    = 2'd0;
    localparam logic [1:0] ALU_SRC_SEXT  = 2'd1;
    localparam logic [1:0] ALU_SRC_ZEXT  = 2'd2;
    localparam logic [1:0] ALU_SRC_UPPER = 2'd3;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/ex_operand_stage_imm_extend.sv
// Combinational immediate extender: sign, zero or upper placement of an IMM_W field into DATA_W bits.
module imm_extend
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] ext
);

    localparam int unsigned PAD_W = DATA_W - IMM_W;

    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] upper;

    // A full-width immediate has nothing to pad, so every mode passes it through.
    generate
        if (PAD_W == 0) begin : g_full
            assign sext  = imm;
            assign zext  = imm;
            assign upper = imm;
        end else begin : g_pad
            assign sext  = {{PAD_W{imm[IMM_W-1]}}, imm};
            assign zext  = {{PAD_W{1'b0}}, imm};
            assign upper = {imm, {PAD_W{1'b0}}};
        end
    endgenerate

    always_comb begin
        ext = sext;
        case (mode)
            ALU_SRC_ZEXT:  ext = zext;
            ALU_SRC_UPPER: ext = upper;
            default:       ext = sext;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// EX-stage operand selection: forwarding for both operands, immediate select for B, registered
// into the EX/MEM boundary with stall (hold) and flush (bubble) control.
module ex_operand_stage
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        alu_src,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [DATA_W-1:0] data_rs,
    input  logic [DATA_W-1:0] data_rt,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] fwd_mem,
    input  logic [DATA_W-1:0] fwd_wb,
    output logic              out_valid,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] store_data
);

    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] rt_fwd;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] b_next;

    // Forwarding muxes; the reserved code falls back to the register file.
    always_comb begin
        a_next = data_rs;
        case (fwd_a)
            FWD_MEM: a_next = fwd_mem;
            FWD_WB:  a_next = fwd_wb;
            default: a_next = data_rs;
        endcase
    end

    always_comb begin
        rt_fwd = data_rt;
        case (fwd_b)
            FWD_MEM: rt_fwd = fwd_mem;
            FWD_WB:  rt_fwd = fwd_wb;
            default: rt_fwd = data_rt;
        endcase
    end

    imm_extend #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_imm_extend (
        .imm  (imm),
        .mode (alu_src),
        .ext  (imm_ext)
    );

    assign b_next = (alu_src == ALU_SRC_RT) ? rt_fwd : imm_ext;

    // EX/MEM boundary register: reset, then flush, then stall, then load.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            out_valid  <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            store_data <= '0;
        end else if (!stall) begin
            out_valid  <= in_valid;
            op_a       <= a_next;
            op_b       <= b_next;
            store_data <= rt_fwd;
        end
    end

endmodule
